// File: rtl/xbus_dma_gen.sv
// rtl/xbus_dma_gen.sv - Xbus DMA soak generator/checker over a 2^WC_BITS word window.
// Read-back compare, err_count and err_addr exist only when XBUS_DMA_GEN_CHECK_EN is defined.
module xbus_dma_gen #(
   parameter logic [21:0] ADDR_BASE  = 22'h001000,
   parameter int          WC_BITS    = 8,
   parameter int          GAP_CYCLES = 2,
   parameter int          MODE       = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [21:0] addrin,
   input  logic [31:0] datain,
   input  logic        reqin,
   input  logic        ackin,
   input  logic        busgrantin,
   input  logic        writein,
   input  logic        decodein,
   output logic [21:0] addrout,
   output logic [31:0] dataout,
   output logic        reqout,
   output logic        ackout,
   output logic        busreqout,
   output logic        writeout,
   output logic        decodeout,
   output logic        interrupt,
   output logic [15:0] pass_count,
   output logic [15:0] err_count,
   output logic [21:0] err_addr,
   output logic [3:0]  gen_state
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0, S_INIT = 4'd1, S_GAP  = 4'd2, S_MWR  = 4'd3,
      S_MRD  = 4'd4, S_CHK  = 4'd5, S_LAST = 4'd6, S_DONE = 4'd7
   } state_t;

   localparam logic [WC_BITS-1:0] WC_ONE   = 1;
   localparam logic [3:0]         GAP_LOAD = 4'(GAP_CYCLES - 1);

   state_t               state_q, state_d;
   logic [WC_BITS-1:0]   wc_q, wc_d;
   logic [3:0]           gap_q, gap_d;
   logic [15:0]          pass_q, pass_d;
   logic                 dir_q, dir_d;
   logic                 xfer_done, wc_last, in_xfer;
   state_t               xfer_state, after_word;
   logic                 unused_inputs;

   assign unused_inputs = ^{addrin, reqin, writein, decodein, datain};

   assign xfer_state = (MODE == 1 || (MODE == 0 && !dir_q)) ? S_MWR : S_MRD;
   assign wc_last    = &wc_q;
   assign xfer_done  = busgrantin & ackin;
   // With no gap configured the next word is requested straight away.
   assign after_word = wc_last ? S_LAST : ((GAP_CYCLES == 0) ? xfer_state : S_GAP);

`ifdef XBUS_DMA_GEN_CHECK_EN
   logic [31:0] hold_q, hold_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic [21:0] err_addr_q, err_addr_d;
   logic [31:0] expected;
   logic        do_cmp;

   assign expected = {pass_q[7:0] - 8'd1, 24'(wc_q)};
   assign do_cmp   = (MODE != 2) && (pass_q != 16'd0);
`endif

   always_comb begin
      state_d = state_q;
      wc_d    = wc_q;
      gap_d   = gap_q;
      pass_d  = pass_q;
      dir_d   = dir_q;
`ifdef XBUS_DMA_GEN_CHECK_EN
      hold_d     = hold_q;
      err_cnt_d  = err_cnt_q;
      err_addr_d = err_addr_q;
`endif
      case (state_q)
         S_IDLE: if (enable) state_d = S_INIT;
         S_INIT: begin
            wc_d    = '0;
            gap_d   = GAP_LOAD;
            state_d = xfer_state;
         end
         S_GAP: begin
            if (gap_q == 4'd0) state_d = xfer_state;
            else               gap_d   = gap_q - 4'd1;
         end
         S_MWR: begin
            if (xfer_done) begin
               wc_d    = wc_last ? wc_q : wc_q + WC_ONE;
               gap_d   = GAP_LOAD;
               state_d = after_word;
            end
         end
         S_MRD: begin
            if (xfer_done) begin
`ifdef XBUS_DMA_GEN_CHECK_EN
               hold_d  = datain;
               state_d = S_CHK;
`else
               wc_d    = wc_last ? wc_q : wc_q + WC_ONE;
               gap_d   = GAP_LOAD;
               state_d = after_word;
`endif
            end
         end
`ifdef XBUS_DMA_GEN_CHECK_EN
         S_CHK: begin
            if (do_cmp && hold_q != expected) begin
               if (err_cnt_q != 16'hffff) err_cnt_d  = err_cnt_q + 16'd1;
               if (err_cnt_q == 16'd0)    err_addr_d = ADDR_BASE + 22'(wc_q);
            end
            wc_d    = wc_last ? wc_q : wc_q + WC_ONE;
            gap_d   = GAP_LOAD;
            state_d = after_word;
         end
`endif
         S_LAST: state_d = S_DONE;
         S_DONE: begin
            pass_d  = pass_q + 16'd1;
            if (MODE == 0) dir_d = ~dir_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         wc_q       <= '0;
         gap_q      <= '0;
         pass_q     <= '0;
         dir_q      <= 1'b0;
`ifdef XBUS_DMA_GEN_CHECK_EN
         hold_q     <= '0;
         err_cnt_q  <= '0;
         err_addr_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         wc_q       <= wc_d;
         gap_q      <= gap_d;
         pass_q     <= pass_d;
         dir_q      <= dir_d;
`ifdef XBUS_DMA_GEN_CHECK_EN
         hold_q     <= hold_d;
         err_cnt_q  <= err_cnt_d;
         err_addr_q <= err_addr_d;
`endif
      end
   end

   // Bus outputs decode the state register, so an async reset drops them at once.
   assign in_xfer    = (state_q == S_MWR) || (state_q == S_MRD);
   assign busreqout  = in_xfer;
   assign reqout     = in_xfer;
   assign writeout   = (state_q == S_MWR);
   assign addrout    = in_xfer ? ADDR_BASE + 22'(wc_q) : 22'd0;
   assign dataout    = (state_q == S_MWR && busgrantin) ? {pass_q[7:0], 24'(wc_q)} : 32'd0;
   assign ackout     = 1'b0;
   assign decodeout  = 1'b0;
   assign interrupt  = (state_q == S_DONE);
   assign pass_count = pass_q;
   assign gen_state  = state_q;
`ifdef XBUS_DMA_GEN_CHECK_EN
   assign err_count  = err_cnt_q;
   assign err_addr   = err_addr_q;
`else
   assign err_count  = 16'd0;
   assign err_addr   = 22'd0;
`endif

endmodule
